// File: rtl/vga_controller.sv
// 640x480@60 VGA raster generator: issues upcoming pixel coordinates to the
// frame-buffer fetch, then drives gated colour with sync/blank aligned two cycles later.
module vga_controller #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_ACT   = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_ACT   = 480,
  parameter int V_FRONT = 10
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [3:0] iCursor_RGB_EN,
  input  logic [9:0] iRed,
  input  logic [9:0] iGreen,
  input  logic [9:0] iBlue,
  output logic [9:0] oCoord_X,
  output logic [9:0] oCoord_Y,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B,
  output logic       oVGA_H_SYNC,
  output logic       oVGA_V_SYNC,
  output logic       oVGA_BLANK,
  output logic       oVGA_SYNC
);

  localparam logic [9:0] C_H_SYNC = 10'(H_SYNC);
  localparam logic [9:0] C_H_ST   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] C_H_END  = 10'(H_SYNC + H_BACK + H_ACT);
  localparam logic [9:0] C_H_LAST = 10'(H_SYNC + H_BACK + H_ACT + H_FRONT - 1);
  localparam logic [9:0] C_V_SYNC = 10'(V_SYNC);
  localparam logic [9:0] C_V_ST   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] C_V_END  = 10'(V_SYNC + V_BACK + V_ACT);
  localparam logic [9:0] C_V_LAST = 10'(V_SYNC + V_BACK + V_ACT + V_FRONT - 1);

  logic [9:0] r_h, r_v;
  logic [9:0] w_h_nxt, w_v_nxt;
  logic       w_h_wrap, w_v_wrap;
  logic       w_act_cur, w_act_nxt;
  logic [9:0] w_x_nxt, w_y_nxt;

  logic       r_act1, r_hs1, r_vs1;
  logic [9:0] r_coord_x, r_coord_y;
  logic [9:0] r_red, r_green, r_blue;
  logic       r_hs2, r_vs2, r_blank;

  logic       w_unused_en3;
  assign w_unused_en3 = iCursor_RGB_EN[3];

  assign w_h_wrap = (r_h == C_H_LAST);
  assign w_v_wrap = (r_v == C_V_LAST);

  // The counter's next value doubles as the coordinate lookahead: the
  // coordinate register loaded from it leads the pins by two cycles.
  always_comb begin
    w_h_nxt = r_h + 10'd1;
    w_v_nxt = r_v;
    if (w_h_wrap) begin
      w_h_nxt = '0;
      w_v_nxt = w_v_wrap ? '0 : r_v + 10'd1;
    end
  end

  assign w_act_cur = (r_h >= C_H_ST) && (r_h < C_H_END) &&
                     (r_v >= C_V_ST) && (r_v < C_V_END);
  assign w_act_nxt = (w_h_nxt >= C_H_ST) && (w_h_nxt < C_H_END) &&
                     (w_v_nxt >= C_V_ST) && (w_v_nxt < C_V_END);

  always_comb begin
    w_x_nxt = '0;
    w_y_nxt = '0;
    if (w_act_nxt) begin
      w_x_nxt = w_h_nxt - C_H_ST;
      w_y_nxt = w_v_nxt - C_V_ST;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_nxt;
      r_v <= w_v_nxt;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_act1    <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_coord_x <= '0;
      r_coord_y <= '0;
    end else begin
      r_act1    <= w_act_cur;
      r_hs1     <= (r_h >= C_H_SYNC);
      r_vs1     <= (r_v >= C_V_SYNC);
      r_coord_x <= w_x_nxt;
      r_coord_y <= w_y_nxt;
    end
  end

  // Colour arrives one cycle after its coordinate; r_act1 is aligned with it.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_hs2   <= 1'b1;
      r_vs2   <= 1'b1;
      r_blank <= 1'b0;
    end else begin
      r_red   <= (r_act1 && iCursor_RGB_EN[2]) ? iRed   : '0;
      r_green <= (r_act1 && iCursor_RGB_EN[1]) ? iGreen : '0;
      r_blue  <= (r_act1 && iCursor_RGB_EN[0]) ? iBlue  : '0;
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;
      r_blank <= r_act1;
    end
  end

  assign oCoord_X    = r_coord_x;
  assign oCoord_Y    = r_coord_y;
  assign oVGA_R      = r_red;
  assign oVGA_G      = r_green;
  assign oVGA_B      = r_blue;
  assign oVGA_H_SYNC = r_hs2;
  assign oVGA_V_SYNC = r_vs2;
  assign oVGA_BLANK  = r_blank;
  assign oVGA_SYNC   = 1'b1;

endmodule

// File: tb/tb_vga_controller.sv
// Randomized bench for vga_controller: a reduced-geometry instance is checked
// every cycle against a positional model; a default instance checks real line timing.
module tb_vga_controller;

  localparam int HS = 8, HB = 6, HA = 20, HF = 4;
  localparam int VS = 2, VB = 3, VA = 6, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FR = HT * VT;
  localparam int DHS = 96, DHB = 48, DHA = 640, DHT = 800;
  localparam int DVS = 2, DVB = 33, DVA = 480, DVT = 525;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en = 4'b0111;
  logic [9:0] ir = '1, ig = '1, ib = '1;

  logic [9:0] cx, cy, vr, vg, vb;
  logic       hs, vs, blank, sync;
  logic [9:0] dcx, dcy, dvr, dvg, dvb;
  logic       dhs, dvs, dblank, dsync;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [9:0] pr = '0, pg = '0, pb = '0;
  logic [3:0] pen = '0;
  logic [9:0] lx = '0, ly = '0;
  int         blank_cnt = 0, hs_lo_cnt = 0, vs_lo_cnt = 0;

  always #5 clk = ~clk;

  vga_controller #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF)
  ) u_dut (
    .iCLK(clk), .iRST_N(rst_n), .iCursor_RGB_EN(en),
    .iRed(ir), .iGreen(ig), .iBlue(ib),
    .oCoord_X(cx), .oCoord_Y(cy),
    .oVGA_R(vr), .oVGA_G(vg), .oVGA_B(vb),
    .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_BLANK(blank), .oVGA_SYNC(sync)
  );

  vga_controller u_dflt (
    .iCLK(clk), .iRST_N(rst_n), .iCursor_RGB_EN(en),
    .iRed(ir), .iGreen(ig), .iBlue(ib),
    .oCoord_X(dcx), .oCoord_Y(dcy),
    .oVGA_R(dvr), .oVGA_G(dvg), .oVGA_B(dvb),
    .oVGA_H_SYNC(dhs), .oVGA_V_SYNC(dvs), .oVGA_BLANK(dblank), .oVGA_SYNC(dsync)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Position model: pixel index since start of frame 0 -> line layout.
  function automatic void model(input int pos, input int ht, input int vt,
                                input int h0, input int ha, input int v0, input int va,
                                output int p, output int l, output bit act,
                                output int x, output int y);
    p   = pos % ht;
    l   = (pos / ht) % vt;
    act = (p >= h0) && (p < h0 + ha) && (l >= v0) && (l < v0 + va);
    x   = act ? p - h0 : 0;
    y   = act ? l - v0 : 0;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_rgb"}, {2'b0, vr, vg, vb}, 32'd0);
    check({tag, "_coord"}, {12'b0, cx, cy}, 32'd0);
    check({tag, "_sync"}, {28'b0, hs, vs, blank, sync}, 32'b1101);
    check({tag, "_dflt"}, {11'b0, dcx, dcy, dhs, dvs, dblank, dsync}, 32'b1101);
  endtask

  task automatic drive(input int mode);
    case (mode)
      0: begin ir = lx; ig = ly; ib = lx ^ ly; end
      1: begin
        ir = 10'($urandom_range(0, 1023));
        ig = 10'($urandom_range(0, 1023));
        ib = 10'($urandom_range(0, 1023));
        en = 4'($urandom_range(0, 15));
      end
      default: begin ir = '1; ig = '1; ib = '1; end
    endcase
    pr = ir; pg = ig; pb = ib; pen = en;
    lx = cx; ly = cy;
  endtask

  task automatic step(input int mode);
    int p, l, x, y;
    bit a;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == 1) begin
      check("first_pins", {2'b0, vr, vg, vb}, 32'd0);
      check("first_sync", {28'b0, hs, vs, blank, sync}, 32'b1101);
    end else begin
      model(cyc - 2, HT, VT, HS + HB, HA, VS + VB, VA, p, l, a, x, y);
      check("R", vr, (a && pen[2]) ? pr : 10'd0);
      check("G", vg, (a && pen[1]) ? pg : 10'd0);
      check("B", vb, (a && pen[0]) ? pb : 10'd0);
      check("HS", hs, (p >= HS) ? 1 : 0);
      check("VS", vs, (l >= VS) ? 1 : 0);
      check("BLANK", {blank, sync}, {a, 1'b1});
      if (cyc - 2 < 2 * FR) begin
        blank_cnt += blank ? 1 : 0;
        hs_lo_cnt += hs ? 0 : 1;
        vs_lo_cnt += vs ? 0 : 1;
      end
      model(cyc - 2, DHT, DVT, DHS + DHB, DHA, DVS + DVB, DVA, p, l, a, x, y);
      check("D_SYNC", {28'b0, dhs, dvs, dblank, dsync}, {28'b0, p >= DHS, l >= DVS, a, 1'b1});
    end
    model(cyc, HT, VT, HS + HB, HA, VS + VB, VA, p, l, a, x, y);
    check("COORD", {12'b0, cx, cy}, {12'b0, 10'(x), 10'(y)});
    model(cyc, DHT, DVT, DHS + DHB, DHA, DVS + DVB, DVA, p, l, a, x, y);
    check("D_COORD", {12'b0, dcx, dcy}, {12'b0, 10'(x), 10'(y)});
    drive(mode);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0; lx = '0; ly = '0;
    blank_cnt = 0; hs_lo_cnt = 0; vs_lo_cnt = 0;
    #1;
    check_idle("rel");
    drive(0);
  endtask

  task automatic check_periods(input string tag);
    check({tag, "_blank_cnt"}, blank_cnt, 2 * HA * VA);
    check({tag, "_hs_lo_cnt"}, hs_lo_cnt, 2 * VT * HS);
    check({tag, "_vs_lo_cnt"}, vs_lo_cnt, 2 * VS * HT);
  endtask

  initial begin
    int budget;
    rst_n = 1'b0;
    en = 4'b0111;
    ir = '1; ig = '1; ib = '1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_idle("rst");
    end
    release_reset();

    en = 4'b0111;
    repeat (2 * FR + 1) step(0);
    check_periods("start");

    en = 4'b0011;
    repeat (FR) step(2);
    en = 4'b1000;
    repeat (FR) step(2);
    repeat (FR) step(1);

    en = 4'b0111;
    budget = FR + 1;
    while (((cyc - 2) % FR) != (7 * HT + 15) && budget > 0) begin
      step(0);
      budget--;
    end
    check("midframe_reach", budget > 0 ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_idle("hold_rst");
    end
    release_reset();
    en = 4'b0111;
    repeat (2 * FR + 1) step(0);
    check_periods("restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
